// File: rtl/mem_arbiter.sv
// Two-client memory arbiter: merges instruction- and data-cache command and
// write-data traffic onto one memory port and steers untagged, in-order read
// beats back to the client that issued each read.
module mem_arbiter #(
  parameter int ADDR_BITS  = 28,
  parameter int DATA_BITS  = 128,
  parameter int BEATS      = 4,
  parameter int READ_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ic_req_val,
  output logic                   ic_req_rdy,
  input  logic [ADDR_BITS-1:0]   ic_req_addr,
  input  logic                   ic_req_rw,
  input  logic                   ic_req_data_valid,
  output logic                   ic_req_data_ready,
  input  logic [DATA_BITS-1:0]   ic_req_data_bits,
  input  logic [DATA_BITS/8-1:0] ic_req_data_mask,
  output logic                   ic_resp_val,
  output logic [DATA_BITS-1:0]   ic_resp_data,
  input  logic                   dc_req_val,
  output logic                   dc_req_rdy,
  input  logic [ADDR_BITS-1:0]   dc_req_addr,
  input  logic                   dc_req_rw,
  input  logic                   dc_req_data_valid,
  output logic                   dc_req_data_ready,
  input  logic [DATA_BITS-1:0]   dc_req_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
  output logic                   dc_resp_val,
  output logic [DATA_BITS-1:0]   dc_resp_data,
  output logic                   mem_req_val,
  input  logic                   mem_req_rdy,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_val,
  input  logic [DATA_BITS-1:0]   mem_resp_data
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = $clog2(READ_DEPTH + 1);
  localparam int PTR_W  = (READ_DEPTH > 1) ? $clog2(READ_DEPTH) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(READ_DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(READ_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WDATA = 1'b1
  } state_e;

  state_e                  state_r;
  state_e                  state_nxt_s;
  logic                    prio_r;       // 0: IC preferred, 1: DC preferred
  logic                    lock_val_r;   // a grant was offered but not taken
  logic                    lock_own_r;
  logic                    wown_r;       // owner of the current write burst
  logic [BEAT_W-1:0]       wbeat_r;
  logic [BEAT_W-1:0]       rbeat_r;
  logic [CNT_W-1:0]        rcount_r;
  logic [READ_DEPTH-1:0]   fifo_r;       // read owners, 0 = IC, 1 = DC
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;

  logic ic_elig_s;
  logic dc_elig_s;
  logic grant_s;
  logic cmd_fire_s;
  logic data_fire_s;
  logic resp_fire_s;
  logic push_s;
  logic pop_s;
  logic head_s;

  // Eligibility and grant selection; a stalled grant is held so the command stays stable
  always_comb begin
    ic_elig_s = 1'b0;
    dc_elig_s = 1'b0;
    grant_s   = 1'b0;
    if (state_r == ST_IDLE) begin
      ic_elig_s = ic_req_val && (ic_req_rw || (rcount_r < DEPTH_CNT));
      dc_elig_s = dc_req_val && (dc_req_rw || (rcount_r < DEPTH_CNT));
    end else begin
      ic_elig_s = 1'b0;
      dc_elig_s = 1'b0;
    end
    if (ic_elig_s && dc_elig_s) begin
      if (lock_val_r) begin
        grant_s = lock_own_r;
      end else begin
        grant_s = prio_r;
      end
    end else begin
      grant_s = dc_elig_s;
    end
  end

  // Next-state and command/write-data channel outputs
  always_comb begin
    state_nxt_s        = state_r;
    mem_req_val        = 1'b0;
    ic_req_rdy         = 1'b0;
    dc_req_rdy         = 1'b0;
    mem_req_data_valid = 1'b0;
    ic_req_data_ready  = 1'b0;
    dc_req_data_ready  = 1'b0;
    mem_req_addr       = grant_s ? dc_req_addr : ic_req_addr;
    mem_req_rw         = grant_s ? dc_req_rw : ic_req_rw;
    mem_req_data_bits  = wown_r ? dc_req_data_bits : ic_req_data_bits;
    mem_req_data_mask  = wown_r ? dc_req_data_mask : ic_req_data_mask;
    case (state_r)
      ST_IDLE: begin
        mem_req_val = ic_elig_s || dc_elig_s;
        ic_req_rdy  = mem_req_val && !grant_s && mem_req_rdy;
        dc_req_rdy  = mem_req_val && grant_s && mem_req_rdy;
        if (mem_req_val && mem_req_rdy && mem_req_rw) begin
          state_nxt_s = ST_WDATA;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WDATA: begin
        mem_req_data_valid = wown_r ? dc_req_data_valid : ic_req_data_valid;
        ic_req_data_ready  = !wown_r && mem_req_data_ready;
        dc_req_data_ready  = wown_r && mem_req_data_ready;
        if (mem_req_data_valid && mem_req_data_ready && (wbeat_r == LAST_BEAT)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WDATA;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign cmd_fire_s  = mem_req_val && mem_req_rdy;
  assign data_fire_s = mem_req_data_valid && mem_req_data_ready;
  assign push_s      = cmd_fire_s && !mem_req_rw;
  assign resp_fire_s = mem_resp_val && (rcount_r != {CNT_W{1'b0}});
  assign pop_s       = resp_fire_s && (rbeat_r == LAST_BEAT);
  assign head_s      = fifo_r[rd_ptr_r];

  assign ic_resp_val  = resp_fire_s && !head_s;
  assign dc_resp_val  = resp_fire_s && head_s;
  assign ic_resp_data = mem_resp_data;
  assign dc_resp_data = mem_resp_data;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Round-robin pointer and hold of a granted-but-stalled command
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_r     <= 1'b0;
      lock_val_r <= 1'b0;
      lock_own_r <= 1'b0;
    end else begin
      if (cmd_fire_s) begin
        prio_r <= !grant_s;
      end
      lock_val_r <= mem_req_val && !mem_req_rdy;
      lock_own_r <= grant_s;
    end
  end

  // Write burst owner and beat counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wown_r  <= 1'b0;
      wbeat_r <= {BEAT_W{1'b0}};
    end else if (cmd_fire_s && mem_req_rw) begin
      wown_r  <= grant_s;
      wbeat_r <= {BEAT_W{1'b0}};
    end else if (data_fire_s) begin
      wbeat_r <= (wbeat_r == LAST_BEAT) ? {BEAT_W{1'b0}} : wbeat_r + BEAT_W'(1);
    end
  end

  // Read-owner FIFO storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_r <= {READ_DEPTH{1'b0}};
    end else if (push_s) begin
      fifo_r[wr_ptr_r] <= grant_s;
    end
  end

  // FIFO pointers, outstanding-read count and response beat counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      rcount_r <= {CNT_W{1'b0}};
      rbeat_r  <= {BEAT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
        rbeat_r  <= {BEAT_W{1'b0}};
      end else if (resp_fire_s) begin
        rbeat_r <= rbeat_r + BEAT_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   rcount_r <= rcount_r + CNT_W'(1);
        2'b01:   rcount_r <= rcount_r - CNT_W'(1);
        default: rcount_r <= rcount_r;
      endcase
    end
  end

endmodule
